// File: rtl/dm_pkg.sv
// dm_pkg: DMI request/response types shared with dm_top
package dm;
  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;
  localparam logic [1:0] DTM_SUCCESS = 2'h0;
  localparam logic [1:0] DTM_ERR     = 2'h2;
  localparam logic [1:0] DTM_BUSY    = 2'h3;
  typedef struct packed {
    logic [6:0] addr;
    dtm_op_e    op;
    logic [31:0] data;
  } dmi_req_t;
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;
endpackage

// File: rtl/tapasco_dmi_pkg.sv
// tapasco_dmi_pkg: bridge FSM states, queued request entry and sticky error bit indices
package tapasco_dmi_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_e;
  typedef struct packed {
    dm::dtm_op_e op;
    logic [6:0]  addr;
    logic [31:0] data;
  } req_entry_t;
  localparam int unsigned ERR_RESP    = 0;
  localparam int unsigned ERR_TIMEOUT = 1;
  localparam int unsigned ERR_OVFL    = 2;
endpackage

// File: rtl/fifo_v3.sv
// fifo_v3: synchronous FIFO; push while full is accepted when a pop happens in the same cycle
//   clk_i/rst_ni clock and async active-low reset, flush_i empties the queue,
//   full_o/empty_o/usage_o status, data_i/push_i write side, data_o/pop_i read side
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  dtype                  data_i,
  input  logic                  push_i,
  output dtype                  data_o,
  input  logic                  pop_i
);
  dtype mem_q [DEPTH];
  logic [ADDR_DEPTH-1:0] wr_q, rd_q;
  logic [ADDR_DEPTH:0] cnt_q;
  logic bypass, wr, rd;
  // when full, the write slot equals the slot being popped, so push+pop reuses it
  assign bypass  = FALL_THROUGH && cnt_q == '0 && push_i && pop_i;
  assign wr      = push_i && !bypass && (!full_o || pop_i);
  assign rd      = pop_i && !bypass && cnt_q != '0;
  assign full_o  = cnt_q == (ADDR_DEPTH+1)'(DEPTH);
  assign empty_o = cnt_q == '0 && !(FALL_THROUGH && push_i);
  assign usage_o = cnt_q[ADDR_DEPTH-1:0];
  assign data_o  = (FALL_THROUGH && cnt_q == '0) ? data_i : mem_q[rd_q];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + ADDR_DEPTH'(wr);
      rd_q  <= rd_q + ADDR_DEPTH'(rd);
      cnt_q <= cnt_q + (ADDR_DEPTH+1)'(wr) - (ADDR_DEPTH+1)'(rd);
    end
  end
  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/tapasco_dmi_bridge.sv
// tapasco_dmi_bridge: turns the host's level DMI strobe into dm_top valid/ready transactions
//   host_*  : strobe/op/addr/wdata in; clear, read data, busy, pending count, sticky errors out
//   dmi_*   : request valid/ready/payload and response valid/ready/payload towards dm_top
module tapasco_dmi_bridge
  import tapasco_dmi_pkg::*;
#(
  parameter int unsigned ReqDepth      = 4,
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned DmiAddrWidth  = 7
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      host_req_i,
  input  logic                      host_wr_i,
  input  logic [DmiAddrWidth-1:0]   host_addr_i,
  input  logic [31:0]               host_wdata_i,
  input  logic                      host_clr_i,
  output logic [31:0]               host_rdata_o,
  output logic                      host_busy_o,
  output logic [$clog2(ReqDepth):0] host_pending_o,
  output logic [2:0]                host_err_o,
  output logic                      dmi_req_valid_o,
  input  logic                      dmi_req_ready_i,
  output dm::dmi_req_t              dmi_req_o,
  input  logic                      dmi_resp_valid_i,
  output logic                      dmi_resp_ready_o,
  input  dm::dmi_resp_t             dmi_resp_i
);
  localparam int unsigned AW = $clog2(ReqDepth);
  localparam int unsigned TW = TimeoutCycles > 0 ? $clog2(TimeoutCycles + 1) : 1;
  state_e state_q, state_d;
  req_entry_t new_entry, head, out_q, out_d;
  logic req_q, push, pop, full, empty, ovfl, timeout, resp_ready_q;
  logic [AW-1:0] usage;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0] err_q, err_d;
  assign push      = host_req_i & ~req_q;
  assign pop       = state_q == IDLE && !empty;
  assign ovfl      = push && full && !pop;
  assign new_entry = '{op: host_wr_i ? dm::DTM_WRITE : dm::DTM_READ, addr: 7'(host_addr_i), data: host_wdata_i};
  // a response in the last timer cycle still counts, so timeout requires no response
  assign timeout   = TimeoutCycles != 0 && state_q == WAIT_RESP && !dmi_resp_valid_i &&
                     timer_q == TW'(TimeoutCycles - 1);
  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DEPTH        (ReqDepth),
    .dtype        (req_entry_t)
  ) i_req_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (full),
    .empty_o (empty),
    .usage_o (usage),
    .data_i  (new_entry),
    .push_i  (push),
    .data_o  (head),
    .pop_i   (pop)
  );
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    timer_d = timer_q;
    rdata_d = rdata_q;
    err_d   = host_clr_i ? 3'b000 : err_q;
    err_d[ERR_OVFL] = err_d[ERR_OVFL] | ovfl;
    case (state_q)
      IDLE: if (pop) begin
        out_d   = head;
        state_d = ISSUE;
      end
      ISSUE: if (dmi_req_ready_i) begin
        timer_d = '0;
        state_d = WAIT_RESP;
      end
      WAIT_RESP: if (dmi_resp_valid_i) begin
        state_d = IDLE;
        if (dmi_resp_i.resp != dm::DTM_SUCCESS) err_d[ERR_RESP] = 1'b1;
        else if (out_q.op == dm::DTM_READ) rdata_d = dmi_resp_i.data;
      end else if (timeout) begin
        err_d[ERR_TIMEOUT] = 1'b1;
        state_d = IDLE;
      end else if (timer_q != '1) begin
        timer_d = timer_q + TW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      out_q        <= '{op: dm::DTM_NOP, addr: '0, data: '0};
      timer_q      <= '0;
      rdata_q      <= '0;
      err_q        <= '0;
      req_q        <= 1'b0;
      resp_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      timer_q      <= timer_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      req_q        <= host_req_i;
      resp_ready_q <= state_d != ISSUE;
    end
  end
  // registered so it reads 0 during reset while tracking state_q != ISSUE afterwards
  assign dmi_resp_ready_o = resp_ready_q;
  assign dmi_req_valid_o  = state_q == ISSUE;
  assign dmi_req_o        = '{addr: out_q.addr, op: out_q.op, data: out_q.data};
  assign host_rdata_o     = rdata_q;
  assign host_err_o       = err_q;
  assign host_busy_o      = !empty || state_q != IDLE;
  assign host_pending_o   = {full, usage} + (AW+1)'(state_q != IDLE);
endmodule

// File: tb/tb_tapasco_dmi_bridge.sv
// tb_tapasco_dmi_bridge: directed vector table plus hand sequences for the DMI bridge
module tb_tapasco_dmi_bridge;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic host_req_i = 1'b0, host_wr_i = 1'b0, host_clr_i = 1'b0;
  logic [6:0] host_addr_i = '0;
  logic [31:0] host_wdata_i = '0, host_rdata_o;
  logic host_busy_o, dmi_req_valid_o, dmi_req_ready_i = 1'b0;
  logic dmi_resp_valid_i = 1'b0, dmi_resp_ready_o;
  logic [2:0] host_pending_o, host_err_o;
  dm::dmi_req_t dmi_req_o;
  dm::dmi_resp_t dmi_resp_i = '0;
  int checks = 0, fails = 0;
  always #5 clk_i = ~clk_i;
  tapasco_dmi_bridge #(.ReqDepth(4), .TimeoutCycles(16), .DmiAddrWidth(7)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .host_req_i       (host_req_i),
    .host_wr_i        (host_wr_i),
    .host_addr_i      (host_addr_i),
    .host_wdata_i     (host_wdata_i),
    .host_clr_i       (host_clr_i),
    .host_rdata_o     (host_rdata_o),
    .host_busy_o      (host_busy_o),
    .host_pending_o   (host_pending_o),
    .host_err_o       (host_err_o),
    .dmi_req_valid_o  (dmi_req_valid_o),
    .dmi_req_ready_i  (dmi_req_ready_i),
    .dmi_req_o        (dmi_req_o),
    .dmi_resp_valid_i (dmi_resp_valid_i),
    .dmi_resp_ready_o (dmi_resp_ready_o),
    .dmi_resp_i       (dmi_resp_i)
  );
  typedef struct {
    logic        wr;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rsp_data;
    logic [1:0]  rsp;
    int          dly;
    logic [31:0] exp_rdata;
    logic [2:0]  exp_err;
  } vec_t;
  vec_t vecs [7];
  task automatic tick();
    @(negedge clk_i);
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic strobe(input logic wr, input logic [6:0] addr, input logic [31:0] wd);
    host_wr_i = wr;
    host_addr_i = addr;
    host_wdata_i = wd;
    host_req_i = 1'b1;
    tick();
    host_req_i = 1'b0;
    tick();
  endtask
  task automatic wait_valid();
    int n = 0;
    while (!dmi_req_valid_o && n < 20) begin
      tick();
      n++;
    end
    chk("req_valid", dmi_req_valid_o, 1);
  endtask
  task automatic handshake(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wd);
    wait_valid();
    chk("req_op", dmi_req_o.op, op);
    chk("req_addr", dmi_req_o.addr, addr);
    chk("req_data", dmi_req_o.data, wd);
    dmi_req_ready_i = 1'b1;
    tick();
    dmi_req_ready_i = 1'b0;
    chk("resp_ready_wait", dmi_resp_ready_o, 1);
  endtask
  task automatic respond(input logic [31:0] rd, input logic [1:0] rc);
    dmi_resp_i = '{data: rd, resp: rc};
    dmi_resp_valid_i = 1'b1;
    tick();
    dmi_resp_valid_i = 1'b0;
  endtask
  task automatic serve(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input logic [1:0] rc, input int dly);
    handshake(op, addr, wd);
    repeat (dly) tick();
    respond(rd, rc);
  endtask
  task automatic clear_err();
    host_clr_i = 1'b1;
    tick();
    host_clr_i = 1'b0;
    chk("err_cleared", host_err_o, 0);
  endtask
  initial begin
    int n;
    logic [1:0] seen_op;
    vecs[0] = '{1'b0, 7'h11, 32'h0,        32'h0000_0ABC, 2'd0, 3, 32'h0000_0ABC, 3'b000};
    vecs[1] = '{1'b1, 7'h10, 32'h1,        32'h5555_5555, 2'd0, 1, 32'h0000_0ABC, 3'b000};
    vecs[2] = '{1'b0, 7'h04, 32'h0,        32'h1234_5678, 2'd0, 2, 32'h1234_5678, 3'b000};
    vecs[3] = '{1'b0, 7'h20, 32'h0,        32'h0000_DEAD, 2'd2, 1, 32'h1234_5678, 3'b001};
    vecs[4] = '{1'b1, 7'h7F, 32'hFFFF_FFFF, 32'h0,        2'd3, 0, 32'h1234_5678, 3'b001};
    vecs[5] = '{1'b0, 7'h00, 32'h0,        32'h0,         2'd0, 0, 32'h0,         3'b000};
    vecs[6] = '{1'b0, 7'h3A, 32'h0,        32'hCAFE_F00D, 2'd0, 0, 32'hCAFE_F00D, 3'b000};
    tick();
    chk("rst_valid", dmi_req_valid_o, 0);
    chk("rst_resp_ready", dmi_resp_ready_o, 0);
    chk("rst_req", dmi_req_o, 0);
    chk("rst_pending", host_pending_o, 0);
    chk("rst_busy", host_busy_o, 0);
    chk("rst_err", host_err_o, 0);
    chk("rst_rdata", host_rdata_o, 0);
    rst_ni = 1'b1;
    tick();
    chk("idle_resp_ready", dmi_resp_ready_o, 1);
    // single transactions from the table; strobe pushes, then IDLE pops on the next edge
    for (int i = 0; i < 7; i++) begin
      host_wr_i = vecs[i].wr;
      host_addr_i = vecs[i].addr;
      host_wdata_i = vecs[i].wdata;
      host_req_i = 1'b1;
      tick();
      host_req_i = 1'b0;
      chk("push_pending", host_pending_o, 1);
      tick();
      chk("issue_latency", dmi_req_valid_o, 1);
      serve(vecs[i].wr ? 2'd2 : 2'd1, vecs[i].addr, vecs[i].wdata, vecs[i].rsp_data, vecs[i].rsp, vecs[i].dly);
      chk($sformatf("v%0d_rdata", i), host_rdata_o, vecs[i].exp_rdata);
      chk($sformatf("v%0d_err", i), host_err_o, vecs[i].exp_err);
      chk($sformatf("v%0d_busy", i), host_busy_o, 0);
      if (vecs[i].exp_err != 0) clear_err();
    end
    // level held high: only one write, stale responses in IDLE ignored
    n = 0;
    seen_op = 2'd0;
    host_wr_i = 1'b1;
    host_addr_i = 7'h10;
    host_wdata_i = 32'h1;
    host_req_i = 1'b1;
    dmi_resp_i = '{data: 32'h9999, resp: 2'd0};
    for (int c = 0; c < 50; c++) begin
      tick();
      dmi_resp_valid_i = 1'b1;
      dmi_req_ready_i = dmi_req_valid_o;
      if (dmi_req_valid_o) begin
        n++;
        seen_op = dmi_req_o.op;
      end
    end
    host_req_i = 1'b0;
    dmi_resp_valid_i = 1'b0;
    dmi_req_ready_i = 1'b0;
    tick();
    tick();
    chk("hold_count", n, 1);
    chk("hold_op", seen_op, 2);
    chk("hold_rdata", host_rdata_o, 32'hCAFE_F00D);
    chk("hold_err", host_err_o, 0);
    chk("hold_busy", host_busy_o, 0);
    // burst of 6 with ready low: 1 in flight + 4 queued, 6th dropped
    for (int i = 1; i <= 6; i++) strobe(1'b0, 7'(i), 32'(i * 16));
    chk("burst_pending", host_pending_o, 5);
    chk("burst_err", host_err_o, 3'b100);
    chk("burst_busy", host_busy_o, 1);
    for (int i = 1; i <= 5; i++) serve(2'd1, 7'(i), 32'(i * 16), 32'h100 + 32'(i), 2'd0, 0);
    n = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (dmi_req_valid_o) n++;
    end
    chk("burst_no_extra", n, 0);
    chk("burst_drained", host_pending_o, 0);
    chk("burst_rdata", host_rdata_o, 32'h105);
    clear_err();
    // timeout after 16 WAIT_RESP cycles
    strobe(1'b0, 7'h22, 32'h0);
    handshake(2'd1, 7'h22, 32'h0);
    repeat (15) tick();
    chk("to_not_yet", host_err_o, 0);
    chk("to_busy", host_busy_o, 1);
    tick();
    chk("to_err", host_err_o, 3'b010);
    chk("to_idle", host_busy_o, 0);
    chk("late_ready", dmi_resp_ready_o, 1);
    respond(32'h0BAD, 2'd2);
    chk("late_rdata", host_rdata_o, 32'h105);
    chk("late_err", host_err_o, 3'b010);
    clear_err();
    strobe(1'b0, 7'h23, 32'h0);
    serve(2'd1, 7'h23, 32'h0, 32'h77, 2'd0, 1);
    chk("after_to_rdata", host_rdata_o, 32'h77);
    chk("after_to_err", host_err_o, 0);
    // response on the last timer cycle beats the timeout
    strobe(1'b0, 7'h24, 32'h0);
    handshake(2'd1, 7'h24, 32'h0);
    repeat (15) tick();
    respond(32'h5A5A, 2'd0);
    chk("race_rdata", host_rdata_o, 32'h5A5A);
    chk("race_err", host_err_o, 0);
    // error and clear in the same cycle: error stays
    strobe(1'b0, 7'h25, 32'h0);
    handshake(2'd1, 7'h25, 32'h0);
    host_clr_i = 1'b1;
    respond(32'hDEAD, 2'd2);
    host_clr_i = 1'b0;
    chk("clr_race_err", host_err_o, 3'b001);
    chk("clr_race_rdata", host_rdata_o, 32'h5A5A);
    clear_err();
    // asynchronous reset while ISSUE is active
    strobe(1'b0, 7'h30, 32'h0);
    wait_valid();
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_valid", dmi_req_valid_o, 0);
    chk("arst_pending", host_pending_o, 0);
    chk("arst_busy", host_busy_o, 0);
    tick();
    tick();
    rst_ni = 1'b1;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (dmi_req_valid_o) n++;
    end
    chk("arst_no_req", n, 0);
    chk("arst_rdata", host_rdata_o, 0);
    chk("arst_idle_busy", host_busy_o, 0);
    chk("arst_op_nop", dmi_req_o.op, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/tapasco_dmi_bridge.md
Name: tapasco_dmi_bridge

Overview:
Converts the TaPaSCo host's level-based DMI register strobe into the dm::dmi_req_t / dmi_resp_t valid/ready handshake expected by dm_top. Sits between the host register file and dm_top's DMI port, replacing the direct combinational hookup. Adds four things:
- edge-detected request issue, so one strobe produces exactly one request;
- a parametrised request queue;
- sticky read-data capture;
- response error reporting and a timeout watchdog.

Parameters:
ReqDepth, 4, request queue depth; power of two, >=2
TimeoutCycles, 1024, WAIT_RESP cycles before abort; 0 disables timeout
DmiAddrWidth, 7, DMI address width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
host_req_i  in  1  level request strobe; rising edge enqueues one request
host_wr_i  in  1  1=write, 0=read; sampled on the rising edge of host_req_i
host_addr_i  in  DmiAddrWidth  DMI address; sampled on the rising edge
host_wdata_i  in  32  write data; sampled on the rising edge
host_clr_i  in  1  clears the sticky error flags
host_rdata_o  out  32  data from the last successful read response
host_busy_o  out  1  queue non-empty or FSM not IDLE
host_pending_o  out  $clog2(ReqDepth)+1  queued plus in-flight request count
host_err_o  out  3  sticky flags {overflow, timeout, dmi_resp_err}
dmi_req_valid_o  out  1  request valid towards dm_top
dmi_req_ready_i  in  1  dm_top request ready
dmi_req_o  out  dm::dmi_req_t  op / addr / data
dmi_resp_valid_i  in  1  dm_top response valid
dmi_resp_ready_o  out  1  response ready
dmi_resp_i  in  dm::dmi_resp_t  data, resp

Behaviour:
- Reset (asynchronous, active-low): all outputs 0; FSM in IDLE; queue empty; req_q (previous host_req_i) cleared; dmi_req_o.op = DTM_NOP.
- Edge detect: push = host_req_i & ~req_q. The pushed entry is {op = wr ? DTM_WRITE : DTM_READ, addr, wdata}. A level held high generates no further requests.
- Queue full:
  - A push while full and no pop in the same cycle is dropped and sets err[2].
  - Push and pop in the same cycle while full is accepted.
- FSM states:
  - IDLE: if the queue is non-empty, pop the head into the out register and go to ISSUE (1-cycle latency from push to dmi_req_valid_o when the queue was empty).
  - ISSUE: dmi_req_valid_o = 1 with dmi_req_o stable until dmi_req_ready_i. On handshake, clear the timer and go to WAIT_RESP.
  - WAIT_RESP: dmi_resp_ready_o = 1.
    - On dmi_resp_valid_i: if resp != DTM_SUCCESS, set err[0]; else if op == READ, latch host_rdata_o = dmi_resp_i.data. Then go to IDLE.
    - If TimeoutCycles != 0 and the timer reaches TimeoutCycles-1 without a response: set err[1] and go to IDLE.
- Late responses: dmi_resp_ready_o is also 1 in IDLE. A response arriving in IDLE (stale, after a timeout) is consumed and discarded; it does not update rdata or err.
- Response in the same cycle the timeout fires: the response wins; no timeout flag is set.
- host_rdata_o changes only on a successful read response. Writes and errors leave it unchanged.
- Timer width: $clog2(TimeoutCycles+1). The timer saturates and never wraps.
- host_pending_o = queue count + (FSM != IDLE). Maximum value is ReqDepth+1.
- Sticky errors:
  - host_clr_i clears err one cycle later.
  - If host_clr_i and a new error occur in the same cycle, the error wins (it stays set).
- Reset mid-transaction: everything is dropped immediately. dm_top receives dmi_rst_ni from the same reset, so no orphan response is possible.

Decomposition:
- Package tapasco_dmi_pkg:
  - state_e {IDLE, ISSUE, WAIT_RESP};
  - req_entry_t {op, addr, data};
  - err bit index localparams ERR_RESP=0, ERR_TIMEOUT=1, ERR_OVFL=2.
- The request queue is an instance of common_cells fifo_v3 (DEPTH = ReqDepth, dtype = req_entry_t, FALL_THROUGH = 0). No other sub-module is needed.

Test Plan:
1. Single read: rising edge with addr 0x11; dm_top returns data 0x0000_0ABC, resp 0 after 3 cycles -> exactly one DTM_READ handshake, host_rdata_o = 0xABC, err = 0, busy drops one cycle after the response.
2. Level hold: host_req_i held high for 50 cycles with wr=1, addr 0x10, wdata 0x1 -> exactly one DTM_WRITE issued; host_rdata_o unchanged.
3. Burst and overflow (ReqDepth=4, dmi_req_ready_i held low): 6 strobes -> pending = 5, err[2] = 1; release ready -> exactly 5 requests issued in FIFO order.
4. Timeout (TimeoutCycles=16): dm_top never responds -> err[1] set after 16 WAIT_RESP cycles. A response injected later is consumed with no rdata change; the next request proceeds normally.
5. Error response: read returns resp = DTM_ERR with data 0xDEAD -> err[0] = 1, host_rdata_o keeps its previous value; host_clr_i pulse -> err = 0.
6. Async reset asserted during ISSUE -> dmi_req_valid_o = 0 in the same cycle, pending = 0; after reset release the bridge is idle with no spurious request.
